// File: rtl/uart_tx_arbiter.sv
// Two-requester 8N1 UART transmitter with round-robin byte arbitration.
// Optional packet lock (grant held until last=1): define UART_TX_ARBITER_PACKET_LOCK_EN.
module uart_tx_arbiter #(
  parameter int unsigned CLK_DIV = 868
) (
  input  logic       io_mainClk,
  input  logic       io_asyncResetn,
  input  logic       io_reqA_valid,
  input  logic [7:0] io_reqA_payload,
  input  logic       io_reqA_last,
  output logic       io_reqA_ready,
  input  logic       io_reqB_valid,
  input  logic [7:0] io_reqB_payload,
  input  logic       io_reqB_last,
  output logic       io_reqB_ready,
  output logic       io_uart_txd,
  output logic       io_busy,
  output logic [1:0] io_grant
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned BYTE_W = 8;
  localparam logic [CNT_W-1:0] BIT_RELOAD = CNT_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(BYTE_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [BYTE_W-1:0]   shift_q, shift_d;
  logic [1:0]          owner_q, owner_d;
  logic                prio_b_q, prio_b_d;
  logic                txd_q, txd_d;
  logic                busy_q, busy_d;
  logic [1:0]          grant_q, grant_d;
  logic                elig_a, elig_b;
  logic                pick_a, pick_b;
  logic                xfer;
  logic                cnt_zero;

`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
  logic lock_q, lock_d;
  logic lock_b_q, lock_b_d;
`else
  logic unused_last;
  assign unused_last = io_reqA_last ^ io_reqB_last;
`endif

  // Eligibility and priority pick; a held lock admits only its owner
  always_comb begin
    elig_a = io_reqA_valid;
    elig_b = io_reqB_valid;
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
    if (lock_q) begin
      elig_a = io_reqA_valid & ~lock_b_q;
      elig_b = io_reqB_valid &  lock_b_q;
    end
`endif
    pick_a = elig_a & (~elig_b | ~prio_b_q);
    pick_b = elig_b & (~elig_a |  prio_b_q);
  end

  // Ready is masked by reset so it drops the instant reset asserts
  assign io_reqA_ready = (state_q == IDLE) & io_asyncResetn & pick_a;
  assign io_reqB_ready = (state_q == IDLE) & io_asyncResetn & pick_b;
  assign xfer          = io_reqA_ready | io_reqB_ready;
  assign cnt_zero      = (cnt_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    owner_d  = owner_q;
    prio_b_d = prio_b_q;
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
    lock_d   = lock_q;
    lock_b_d = lock_b_q;
`endif
    case (state_q)
      IDLE: begin
        if (xfer) begin
          state_d  = START;
          cnt_d    = BIT_RELOAD;
          shift_d  = io_reqB_ready ? io_reqB_payload : io_reqA_payload;
          owner_d  = {io_reqB_ready, io_reqA_ready};
          prio_b_d = io_reqA_ready;
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
          lock_d   = io_reqB_ready ? ~io_reqB_last : ~io_reqA_last;
          lock_b_d = io_reqB_ready;
`endif
        end
      end
      START: begin
        if (cnt_zero) begin
          state_d = DATA;
          cnt_d   = BIT_RELOAD;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_zero) begin
          cnt_d = BIT_RELOAD;
          if (bit_q == LAST_BIT) begin
            state_d = STOP;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_zero) begin
          state_d = IDLE;
          owner_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line outputs follow the next state so they change with the state register
    txd_d   = 1'b1;
    busy_d  = (state_d != IDLE);
    grant_d = busy_d ? owner_d : 2'b00;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      owner_q  <= '0;
      prio_b_q <= 1'b0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      grant_q  <= '0;
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
      lock_q   <= 1'b0;
      lock_b_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      owner_q  <= owner_d;
      prio_b_q <= prio_b_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      grant_q  <= grant_d;
`ifdef UART_TX_ARBITER_PACKET_LOCK_EN
      lock_q   <= lock_d;
      lock_b_q <= lock_b_d;
`endif
    end
  end

  assign io_uart_txd = txd_q;
  assign io_busy     = busy_q;
  assign io_grant    = grant_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
REQ-002 io_mainClk  input  1  sole clock, rising edge.
REQ-003 io_asyncResetn  input  1  reset, asynchronous, active-low.
REQ-004 io_reqA_valid  input  1  requester A byte available.
REQ-005 io_reqA_payload  input  8  requester A byte.
REQ-006 io_reqA_last  input  1  requester A byte ends a packet.
REQ-007 io_reqA_ready  output  1  requester A byte accepted this cycle when valid.
REQ-008 io_reqB_valid / io_reqB_payload / io_reqB_last / io_reqB_ready SHALL mirror REQ-004..007 for requester B.
REQ-009 io_uart_txd  output  1  serial line, 8N1, idle high.
REQ-010 io_busy  output  1  frame in progress.
REQ-011 io_grant  output  2  one-hot owner of the current frame (bit0 A, bit1 B); 0 when idle.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 Transfer SHALL occur only when valid and ready are both high in the same cycle.
REQ-014 ready SHALL be high only in IDLE, for exactly one requester, combinationally from state, valids, priority and lock.
REQ-015 IDLE with no eligible valid: remain IDLE, both ready low, txd high.
REQ-016 Single valid requester: that requester is granted.
REQ-017 Both valid: grant the requester holding priority; after any grant, priority passes to the other requester.
REQ-018 On a transfer, latch the payload and owner and go to START the next cycle.
REQ-019 START: txd low for CLK_DIV cycles, then DATA.
REQ-020 DATA: 8 bits LSB first, each held CLK_DIV cycles, then STOP.
REQ-021 STOP: txd high for CLK_DIV cycles, then IDLE.
REQ-022 Frame length SHALL be exactly 10*CLK_DIV cycles, from the cycle after the transfer.
REQ-023 Back-to-back bytes SHALL have exactly one IDLE cycle (txd high) between STOP end and the next START.
REQ-024 The bit-timing counter SHALL be 16 bits, reload to CLK_DIV-1 at each bit start, and count down to 0.
REQ-025 io_busy SHALL be high in START, DATA and STOP; io_grant SHALL hold the owner's bit through those states.
REQ-026 Input changes during a frame SHALL not affect the frame in progress.

Reset
REQ-027 Reset assertion SHALL immediately force: state IDLE, txd 1, both ready 0, busy 0, grant 0, priority A, lock cleared.
REQ-028 Reset mid-frame SHALL abort the frame and discard the latched byte; no partial retransmit after release.
REQ-029 First transfer is possible in the first clock after reset release.

Configuration
REQ-030 With macro UART_TX_ARBITER_PACKET_LOCK_EN defined, accepting a byte with last=0 SHALL lock the grant to its owner.
REQ-031 While locked, only the owner is eligible in IDLE; the other requester waits even if the owner's valid is low.
REQ-032 The lock SHALL be released on accepting the owner's byte with last=1; priority then passes to the other requester.
REQ-033 Without the macro, io_reqX_last SHALL be ignored and arbitration is per byte (REQ-016/017).

Verification (CLK_DIV=4)
REQ-034 A sends 0xA5 alone -> txd low 4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then high 4 cycles; busy high 40 cycles; grant=01.
REQ-035 A and B both valid continuously after reset, A=0x11, B=0x22 -> frame order A,B,A,B; exactly one idle cycle between frames.
REQ-036 Reset asserted at cycle 15 of a frame -> txd high the same cycle; after release, no frame without a new transfer.
REQ-037 Lock on: A sends 3 bytes with last=0,0,1 while B is valid -> A,A,A then B; lock off -> A,B,A,B,A.
REQ-038 Lock on: A sends a byte with last=0, then drops valid for 100 cycles while B is valid -> B never granted until A completes with last=1.
REQ-039 Payload changed mid-frame -> transmitted bits match the byte latched at transfer.
